// File: rtl/sfq_capture_pkg.sv
// Shared definitions for the SFQ toggle-capture stage: default sizes, the
// buffered event record and a power-of-two helper used for parameter checks.
package sfq_capture_pkg;

    localparam int TS_W_DEF   = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int SYNC_N_DEF = 2;

    // One captured pulse as it sits in the event FIFO (default timestamp width).
    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
    } sfq_event_t;

    // True when n is a positive power of two; used to reject bad FIFO depths.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage : sfq_capture_pkg

// File: rtl/sfq_event_fifo.sv
// Synchronous FIFO of pulse timestamps. Pointers carry one extra wrap bit so
// full and empty can be told apart. The head (rd_valid/rd_ts) is registered:
// data pushed into an empty FIFO becomes visible on the following cycle.
module sfq_event_fifo
    import sfq_capture_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [TS_W-1:0] push_ts,
    input  logic            pop,
    output logic            full,
    output logic            rd_valid,
    output logic [TS_W-1:0] rd_ts
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_depth_check
        $error("sfq_event_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr_nxt;
    logic [PW-1:0]   rd_ptr_nxt;
    logic            empty;
    logic            do_push;
    logic            do_pop;
    logic            head_valid_nxt;
    logic [TS_W-1:0] head_ts_nxt;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointers and next head; bypass the write data when the entry being
    // written this cycle is the one that becomes the head.
    always_comb begin
        wr_ptr_nxt     = do_push ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_nxt     = do_pop  ? rd_ptr + PW'(1) : rd_ptr;
        head_valid_nxt = (wr_ptr_nxt != rd_ptr_nxt);
        head_ts_nxt    = '0;
        if (head_valid_nxt) begin
            if (do_push && (rd_ptr_nxt == wr_ptr)) begin
                head_ts_nxt = push_ts;
            end else begin
                head_ts_nxt = mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_ts;
        end
    end

    // Pointer and registered head update; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_ts    <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_valid <= head_valid_nxt;
            rd_ts    <= head_ts_nxt;
        end
    end

endmodule : sfq_event_fifo

// File: rtl/sfq_toggle_capture.sv
// Capture stage for a toggle-encoded SFQ line. Each transition of pulse_in is
// one pulse: the line is synchronised, compared against the mirrored cell
// level, and every accepted pulse is timestamped and queued for a checker.
module sfq_toggle_capture
    import sfq_capture_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SYNC_N = SYNC_N_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pulse_in,
    input  logic            enable,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [TS_W-1:0] rd_ts,
    output logic            level,
    output logic [TS_W-1:0] pulse_cnt,
    output logic            overflow,
    input  logic            clear_ovf
);

    localparam int PCW = $clog2(SYNC_N + 1);

    if (SYNC_N < 2) begin : g_sync_check
        $error("sfq_toggle_capture: SYNC_N must be at least 2");
    end

    logic [SYNC_N-1:0] sync_q;
    logic              sync_out;
    logic [PCW-1:0]    prime_cnt;
    logic              sync_valid;
    logic              primed;
    logic [TS_W-1:0]   ts_cnt;
    logic              evt;
    logic              accept;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_full;

    assign sync_out   = sync_q[SYNC_N-1];
    assign sync_valid = (prime_cnt == PCW'(SYNC_N));
    assign evt        = primed && (sync_out != level);
    assign accept     = evt && enable;
    assign pop        = rd_valid && rd_ready;
    assign push       = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;

    // Synchroniser chain bringing the asynchronous pulse line into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pulse_in};
        end
    end

    // Counts cycles after reset until the chain holds a real sample of pulse_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (!sync_valid) begin
            prime_cnt <= prime_cnt + PCW'(1);
        end
    end

    // Level mirror: first valid sample primes it silently, later changes are events.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed <= 1'b0;
            level  <= 1'b0;
        end else if (!primed) begin
            if (sync_valid) begin
                primed <= 1'b1;
                level  <= sync_out;
            end
        end else if (evt) begin
            level <= sync_out;
        end
    end

    // Free-running timestamp counter, wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // Accepted-pulse counter, holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt <= '0;
        end else if (push && (pulse_cnt != '1)) begin
            pulse_cnt <= pulse_cnt + TS_W'(1);
        end
    end

    // Sticky overflow; a drop in the same cycle as clear_ovf keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    sfq_event_fifo #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_ts  (ts_cnt),
        .pop      (pop),
        .full     (fifo_full),
        .rd_valid (rd_valid),
        .rd_ts    (rd_ts)
    );

endmodule : sfq_toggle_capture
